// File: rtl/fixed_point_dot_accumulator.sv
// fixed_point_dot_accumulator
//   Accumulate stage behind the 16-bit fixed-point multiplier. It sums one
//   product per accepted beat into a guard-bit accumulator. At the end of a
//   vector it emits one saturated DATA_W result together with a sticky
//   overflow flag and the number of terms summed.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   product beat handshake (ready only while accumulating)
//   in_prod             signed product, same Q-format as the result
//   in_prod_ovf         multiplier overflow flag for this product
//   in_last             final product of the current vector
//   out_valid/out_ready result handshake
//   out_sum             saturated dot-product result
//   out_ovf             sticky overflow (multiplier flags | final saturation)
//   out_count           number of terms summed into out_sum (1..MAX_TERMS)
module fixed_point_dot_accumulator #(
  parameter int DATA_W    = 16,
  parameter int GUARD_W   = 4,
  parameter int MAX_TERMS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_prod,
  input  logic              in_prod_ovf,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic [4:0]        out_count
);

  localparam int ACC_W = DATA_W + GUARD_W;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              ovf;
    logic [CNT_W-1:0]  count;
  } result_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] term_cnt, cnt_nxt;
  logic             ovf_sticky, ovf_nxt;
  result_t          res, res_nxt;

  logic accept, vec_end, sat_flag;
  logic [DATA_W-1:0] sat_val;
  logic [ACC_W-DATA_W:0] acc_top;

  assign in_ready = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept = in_valid & in_ready;

  // Running values as they would stand after this beat is accepted.
  assign acc_nxt = acc + {{GUARD_W{in_prod[DATA_W-1]}}, in_prod};
  assign ovf_nxt = ovf_sticky | in_prod_ovf;
  assign cnt_nxt = term_cnt + 1'b1;
  assign vec_end = in_last | (cnt_nxt == MAX_CNT);

  // The value fits DATA_W only if the guard bits and the DATA_W sign bit all
  // agree. Otherwise the accumulator sign selects the rail. Only the final
  // sum is tested, so a transient excursion that comes back into range is
  // not treated as an overflow.
  assign acc_top = acc_nxt[ACC_W-1:DATA_W-1];

  always_comb begin
    sat_flag = 1'b0;
    sat_val  = acc_nxt[DATA_W-1:0];
    if (!((&acc_top) || !(|acc_top))) begin
      sat_flag = 1'b1;
      sat_val  = acc_nxt[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_nxt = state;
    res_nxt   = res;
    case (state)
      ACCUM: begin
        if (accept && vec_end) begin
          state_nxt     = HOLD;
          res_nxt.sum   = sat_val;
          res_nxt.ovf   = ovf_nxt | sat_flag;
          res_nxt.count = cnt_nxt;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      res   <= '0;
    end else begin
      state <= state_nxt;
      res   <= res_nxt;
    end
  end

  // Running accumulation. The registers clear when the vector closes, so the
  // next vector starts from zero without an extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      term_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      if (vec_end) begin
        acc        <= '0;
        term_cnt   <= '0;
        ovf_sticky <= 1'b0;
      end else begin
        acc        <= acc_nxt;
        term_cnt   <= cnt_nxt;
        ovf_sticky <= ovf_nxt;
      end
    end
  end

  assign out_sum   = res.sum;
  assign out_ovf   = res.ovf;
  assign out_count = res.count;

endmodule

// File: tb/tb_fixed_point_dot_accumulator.sv
module tb_fixed_point_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_prod = '0;
  logic        in_prod_ovf = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic [4:0]  out_count;

  int checks = 0;
  int failures = 0;

  logic [15:0] vec_prod[$];
  logic        vec_ovf[$];
  logic        vec_use_last;

  fixed_point_dot_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_prod_ovf(in_prod_ovf), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: the whole vector is summed as a plain integer and then clamped.
  function automatic void model(output logic [15:0] sum, output logic ovf,
                                output logic [4:0] cnt);
    int s = 0;
    logic f = 1'b0;
    foreach (vec_prod[i]) begin
      s += int'($signed(vec_prod[i]));
      f |= vec_ovf[i];
    end
    cnt = 5'(vec_prod.size());
    if (s > 32767) begin
      sum = 16'h7FFF; f = 1'b1;
    end else if (s < -32768) begin
      sum = 16'h8000; f = 1'b1;
    end else begin
      sum = 16'(s);
    end
    ovf = f;
  endfunction

  // Drives vec_prod/vec_ovf, optionally with idle beats that carry junk
  // data. The result is checked one cycle after the final accept.
  task automatic drive_vec(input string name, input bit gaps);
    logic [15:0] e_sum;
    logic e_ovf;
    logic [4:0] e_cnt;
    int k;
    model(e_sum, e_ovf, e_cnt);
    for (int i = 0; i < vec_prod.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(3) == 0) begin
        in_valid = 1'b0; in_prod = 16'($urandom); in_last = 1'b1; in_prod_ovf = 1'b1;
        @(posedge clk); #1;
      end
      k = 0;
      while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
      checks++;
      if (!in_ready) begin
        failures++;
        $display("FAIL %s in_ready: got 0 expected 1 (beat %0d)", name, i);
      end
      in_valid = 1'b1; in_prod = vec_prod[i]; in_prod_ovf = vec_ovf[i];
      in_last = vec_use_last && (i == vec_prod.size() - 1);
      @(posedge clk); #1;
      if (i < vec_prod.size() - 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s early_out_valid: got %b expected 0 (beat %0d)", name, out_valid, i);
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_prod_ovf = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b expected 1/0", name, out_valid, in_ready);
    end
    checks++;
    if (out_sum !== e_sum) begin
      failures++;
      $display("FAIL %s out_sum: got %h expected %h", name, out_sum, e_sum);
    end
    checks++;
    if (out_ovf !== e_ovf) begin
      failures++;
      $display("FAIL %s out_ovf: got %b expected %b", name, out_ovf, e_ovf);
    end
    checks++;
    if (out_count !== e_cnt) begin
      failures++;
      $display("FAIL %s out_count: got %0d expected %0d", name, out_count, e_cnt);
    end
  endtask

  // With out_ready=1 the result is consumed on the next edge.
  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s consume: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic set_vec(input logic [15:0] p[$], input logic use_last);
    vec_prod = p;
    vec_ovf.delete();
    foreach (p[i]) vec_ovf.push_back(1'b0);
    vec_use_last = use_last;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'h0 ||
        out_ovf !== 1'b0 || out_count !== 5'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b ready=%b sum=%h ovf=%b cnt=%0d expected 0/1/0000/0/0",
               out_valid, in_ready, out_sum, out_ovf, out_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    set_vec('{16'h0100, 16'h0200, 16'hFF00}, 1'b1);
    drive_vec("basic", 1'b0);
    consume("basic");
  endtask

  task automatic test_pos_sat();
    logic [15:0] p[$];
    for (int i = 0; i < 16; i++) p.push_back(16'h7000);
    set_vec(p, 1'b0);
    drive_vec("pos_sat", 1'b0);
    consume("pos_sat");
  endtask

  task automatic test_neg_sat();
    set_vec('{16'h8000, 16'hFFFF}, 1'b1);
    drive_vec("neg_sat", 1'b0);
    consume("neg_sat");
  endtask

  task automatic test_transient();
    set_vec('{16'h7000, 16'h7000, 16'h9000}, 1'b1);
    drive_vec("transient", 1'b0);
    consume("transient");
  endtask

  task automatic test_ovf_flag();
    set_vec('{16'h0010, 16'h0010}, 1'b1);
    vec_ovf[0] = 1'b1;
    drive_vec("ovf_flag", 1'b0);
    consume("ovf_flag");
    set_vec('{16'h0001}, 1'b1);
    drive_vec("ovf_clear", 1'b0);
    consume("ovf_clear");
  endtask

  task automatic test_backpressure_reset();
    logic [15:0] held;
    out_ready = 1'b0;
    set_vec('{16'h0123, 16'h0456}, 1'b1);
    drive_vec("bp", 1'b0);
    held = out_sum;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_prod = 16'h1111; in_last = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== held) begin
        failures++;
        $display("FAIL bp_hold: valid=%b ready=%b sum=%h expected 1/0/%h",
                 out_valid, in_ready, out_sum, held);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume("bp");
    // Junk beats offered during HOLD must not show up in this sum.
    set_vec('{16'h0001}, 1'b1);
    drive_vec("bp_after", 1'b0);
    consume("bp_after");
    // Two beats of a vector, then an asynchronous reset in mid-cycle.
    in_valid = 1'b1; in_prod = 16'h0100; in_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_count !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset: out_valid=%b out_count=%0d expected 0/0", out_valid, out_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_vec('{16'h0003}, 1'b1);
    drive_vec("post_reset", 1'b0);
    consume("post_reset");
  endtask

  task automatic test_random();
    int n;
    for (int v = 0; v < 40; v++) begin
      n = $urandom_range(1, 16);
      vec_prod.delete(); vec_ovf.delete();
      for (int i = 0; i < n; i++) begin
        vec_prod.push_back(($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 511) - 256));
        vec_ovf.push_back($urandom_range(7) == 0);
      end
      // Full-length vectors sometimes rely on the term limit to close.
      vec_use_last = (n < 16) || ($urandom_range(1) == 0);
      drive_vec("random", 1'b1);
      if ($urandom_range(1) == 0) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      consume("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_sat();
    test_transient();
    test_ovf_flag();
    test_backpressure_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
